// File: rtl/exec_alu_seq.sv
// Execute-stage ALU: single-cycle arithmetic/logic, iterative shifts of SHIFT_STEP bits per cycle.
// Define EXEC_ALU_BARREL_EN to replace the iterative shifter with a single-cycle barrel shifter.
module exec_alu_seq #(
   parameter int SHIFT_STEP = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   input  logic [2:0]  i_opsel,
   input  logic        i_sub,
   input  logic        i_unsigned,
   input  logic        i_arith,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_result,
   output logic        o_eq,
   output logic        o_lt,
   output logic [1:0]  o_dbg_state
);

   // Input side: op taken when i_valid && o_ready; output side: result taken when o_valid && i_ready.

`ifdef EXEC_ALU_BARREL_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] result_q, result_d;
   logic [31:0] work_q, work_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        left_q, left_d;
   logic        fill_q, fill_d;
   logic        eq_q, eq_d;
   logic        lt_q, lt_d;

   logic [4:0]  shamt;
   logic        is_shift;
   logic        cmp_eq;
   logic        cmp_lt;
   logic        accept;
   logic [31:0] alu_res;
   logic [4:0]  step_amt;
   logic [31:0] shifted;

   assign shamt    = i_op2[4:0];
   assign is_shift = (i_opsel == 3'b001) || (i_opsel == 3'b101);
   assign cmp_eq   = (i_op1 == i_op2);
   assign cmp_lt   = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));

   assign o_ready  = !i_flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready));
   assign accept   = i_valid && o_ready;

   always_comb begin
      alu_res = '0;
      case (i_opsel)
         3'b000:  alu_res = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
         3'b001:  alu_res = BARREL ? (i_op1 << shamt) : i_op1;
         3'b010:  alu_res = i_op2;
         3'b011:  alu_res = {31'b0, cmp_lt};
         3'b100:  alu_res = i_op1 ^ i_op2;
         3'b101: begin
            if (!BARREL)
               alu_res = i_op1;
            else if (i_arith)
               alu_res = $signed(i_op1) >>> shamt;
            else
               alu_res = i_op1 >> shamt;
         end
         3'b110:  alu_res = i_op1 | i_op2;
         3'b111:  alu_res = i_op1 & i_op2;
         default: alu_res = '0;
      endcase
   end

   // Right shifts with a 1-fill are done by inverting around a zero-fill shift.
   assign step_amt = (cnt_q < STEP) ? cnt_q : STEP;
   assign shifted  = left_q ? (work_q << step_amt)
                   : (fill_q ? ~((~work_q) >> step_amt) : (work_q >> step_amt));

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      left_d   = left_q;
      fill_d   = fill_q;
      eq_d     = eq_q;
      lt_d     = lt_q;
      if (i_flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  eq_d = cmp_eq;
                  lt_d = cmp_lt;
                  if (!BARREL && is_shift && (shamt != 5'd0)) begin
                     work_d  = i_op1;
                     cnt_d   = shamt;
                     left_d  = ~i_opsel[2];
                     fill_d  = i_opsel[2] & i_arith & i_op1[31];
                     state_d = ST_SHIFT;
                  end else begin
                     result_d = alu_res;
                     state_d  = ST_DONE;
                  end
               end else if ((state_q == ST_DONE) && i_ready) begin
                  state_d = ST_IDLE;
               end
            end
            ST_SHIFT: begin
               work_d = shifted;
               cnt_d  = cnt_q - step_amt;
               if (cnt_q <= STEP) begin
                  result_d = shifted;
                  state_d  = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         left_q   <= 1'b0;
         fill_q   <= 1'b0;
         eq_q     <= 1'b0;
         lt_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         left_q   <= left_d;
         fill_q   <= fill_d;
         eq_q     <= eq_d;
         lt_q     <= lt_d;
      end
   end

   assign o_valid     = (state_q == ST_DONE);
   assign o_result    = result_q;
   assign o_eq        = eq_q;
   assign o_lt        = lt_q;
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_exec_alu_seq.sv
// Bench for exec_alu_seq: fixed vector table, hand-written corner sequences, randomized ops vs reference model.
module tb_exec_alu_seq;

   localparam int STEP  = 1;
   localparam int STEP4 = 4;

`ifdef EXEC_ALU_BARREL_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        valid = 1'b0;
   logic        rdy = 1'b1;
   logic        v4 = 1'b0;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [2:0]  sel = '0;
   logic        sub = 1'b0;
   logic        uns = 1'b0;
   logic        ar = 1'b0;

   logic        o_ready, o_valid, o_eq, o_lt;
   logic [31:0] o_result;
   logic [1:0]  o_dbg;
   logic        o_ready4, o_valid4, o_eq4, o_lt4;
   logic [31:0] o_result4;
   logic [1:0]  o_dbg4;

   exec_alu_seq #(.SHIFT_STEP(STEP)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
      .i_op1(op1), .i_op2(op2), .i_opsel(sel), .i_sub(sub), .i_unsigned(uns), .i_arith(ar),
      .o_valid(o_valid), .i_ready(rdy), .o_result(o_result), .o_eq(o_eq), .o_lt(o_lt),
      .o_dbg_state(o_dbg)
   );

   exec_alu_seq #(.SHIFT_STEP(STEP4)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_flush(1'b0), .i_valid(v4), .o_ready(o_ready4),
      .i_op1(op1), .i_op2(op2), .i_opsel(sel), .i_sub(sub), .i_unsigned(uns), .i_arith(ar),
      .o_valid(o_valid4), .i_ready(1'b1), .o_result(o_result4), .o_eq(o_eq4), .o_lt(o_lt4),
      .o_dbg_state(o_dbg4)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  sel;
      logic        sub;
      logic        uns;
      logic        ar;
      logic [31:0] res;
      logic        eq;
      logic        lt;
   } vec_t;

   vec_t vt[12];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic int exp_lat(input logic [2:0] s, input logic [31:0] b, input int step);
      int n;
      n = int'(b[4:0]);
      if (!BARREL && (s == 3'b001 || s == 3'b101) && n != 0)
         return 1 + (n + step - 1) / step;
      return 1;
   endfunction

   // Returns {lt, eq, result} computed directly from the operation definitions.
   function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] s, input logic su,
                                             input logic un, input logic ari);
      logic        lt;
      logic        eq;
      logic [31:0] r;
      int          sh;
      lt = un ? (a < b) : ($signed(a) < $signed(b));
      eq = (a == b);
      sh = int'(b[4:0]);
      case (s)
         3'd0:    r = su ? a - b : a + b;
         3'd1:    r = a << sh;
         3'd2:    r = b;
         3'd3:    r = lt ? 32'd1 : 32'd0;
         3'd4:    r = a ^ b;
         3'd5:    r = ari ? 32'($signed(a) >>> sh) : a >> sh;
         3'd6:    r = a | b;
         default: r = a & b;
      endcase
      return {lt, eq, r};
   endfunction

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s,
                           input logic su, input logic un, input logic ari);
      int guard;
      op1 = a; op2 = b; sel = s; sub = su; uns = un; ar = ari;
      valid = 1'b1;
      #1;
      guard = 0;
      while (!o_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!o_ready) chk("accept_timeout", 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic wait_check(input logic [31:0] er, input logic ee, input logic el,
                             input int elat, input string nm);
      int lat;
      lat = 1;
      while (!o_valid && lat < 100) begin
         chk({nm, "_busy_ready"}, 32'(o_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_valid"}, 32'(o_valid), 32'd1);
      chk({nm, "_latency"}, 32'(lat), 32'(elat));
      chk({nm, "_result"}, o_result, er);
      chk({nm, "_eq"}, 32'(o_eq), 32'(ee));
      chk({nm, "_lt"}, 32'(o_lt), 32'(el));
   endtask

   task automatic drain();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [33:0] m;
      logic [31:0] ra, rb;
      logic [2:0]  rs;
      logic        rsu, run, rar;
      int          lat;

      vt[0]  = '{32'h7FFFFFFF, 32'h00000001, 3'b000, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0};
      vt[1]  = '{32'h00000005, 32'h00000007, 3'b000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1};
      vt[2]  = '{32'h80000000, 32'h00000004, 3'b101, 1'b0, 1'b0, 1'b1, 32'hF8000000, 1'b0, 1'b1};
      vt[3]  = '{32'h12345678, 32'h00000020, 3'b001, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0};
      vt[4]  = '{32'hFFFFFFFF, 32'h00000001, 3'b011, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0};
      vt[5]  = '{32'hA5A5A5A5, 32'h0F0F0F0F, 3'b100, 1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b0, 1'b1};
      vt[6]  = '{32'h00000003, 32'h00000003, 3'b010, 1'b0, 1'b0, 1'b0, 32'h00000003, 1'b1, 1'b0};
      vt[7]  = '{32'hF0F01234, 32'h0FF0FFFF, 3'b111, 1'b0, 1'b0, 1'b0, 32'h00F01234, 1'b0, 1'b1};
      vt[8]  = '{32'h12000000, 32'h00000034, 3'b110, 1'b0, 1'b0, 1'b0, 32'h12000034, 1'b0, 1'b0};
      vt[9]  = '{32'h80000000, 32'h0000001F, 3'b101, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b1};
      vt[10] = '{32'h00000001, 32'h0000003F, 3'b001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vt[11] = '{32'hFFFFFFFF, 32'h00000001, 3'b011, 1'b0, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b1};

      // Reset held for two cycles.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_eq", 32'(o_eq), 32'd0);
      chk("rst_lt", 32'(o_lt), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_state", 32'(o_dbg), 32'd0);
      chk("rst_valid4", 32'(o_valid4), 32'd0);

      // sra by 4 on the SHIFT_STEP=4 instance.
      drain();
      op1 = 32'h80000000; op2 = 32'd4; sel = 3'b101; sub = 1'b0; uns = 1'b0; ar = 1'b1;
      v4 = 1'b1;
      #1;
      chk("step4_ready", 32'(o_ready4), 32'd1);
      @(posedge clk); #1;
      v4 = 1'b0;
      lat = 1;
      while (!o_valid4 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("step4_latency", 32'(lat), 32'(exp_lat(3'b101, 32'd4, STEP4)));
      chk("step4_result", o_result4, 32'hF8000000);

      // Table vectors, back-to-back where the previous result is consumed.
      for (int i = 0; i < 12; i++) begin
         drive_op(vt[i].a, vt[i].b, vt[i].sel, vt[i].sub, vt[i].uns, vt[i].ar);
         wait_check(vt[i].res, vt[i].eq, vt[i].lt, exp_lat(vt[i].sel, vt[i].b, STEP),
                    $sformatf("vec%0d", i));
      end

      // Output backpressure, then XOR accepted in the handshake cycle.
      drain();
      rdy = 1'b0;
      drive_op(32'hFFFFFFFF, 32'h1, 3'b011, 1'b0, 1'b1, 1'b0);
      wait_check(32'h0, 1'b0, 1'b0, 1, "bp_slt");
      op1 = 32'hA5A5A5A5; op2 = 32'h0F0F0F0F; sel = 3'b100; uns = 1'b0;
      valid = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp_hold%0d_valid", k), 32'(o_valid), 32'd1);
         chk($sformatf("bp_hold%0d_result", k), o_result, 32'h0);
         chk($sformatf("bp_hold%0d_flags", k), {30'd0, o_eq, o_lt}, 32'd0);
         chk($sformatf("bp_hold%0d_ready", k), 32'(o_ready), 32'd0);
         @(posedge clk); #1;
      end
      rdy = 1'b1;
      #1;
      chk("bp_release_ready", 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      valid = 1'b0;
      chk("b2b_valid", 32'(o_valid), 32'd1);
      chk("b2b_result", o_result, 32'hAAAAAAAA);
      chk("b2b_lt", 32'(o_lt), 32'd1);

      // Flush in the third SHIFT cycle of an srl by 20.
      drain();
      drive_op(32'hFFFF0000, 32'd20, 3'b101, 1'b0, 1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      #1;
      chk("flush_ready_forced", 32'(o_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      chk("flush_valid", 32'(o_valid), 32'd0);
      chk("flush_state", 32'(o_dbg), 32'd0);
      chk("flush_ready", 32'(o_ready), 32'd1);
      drive_op(32'd2, 32'd3, 3'b000, 1'b0, 1'b0, 1'b0);
      wait_check(32'd5, 1'b0, 1'b1, 1, "post_flush_add");

      // Reset while a result sits in DONE under backpressure.
      drain();
      rdy = 1'b0;
      drive_op(32'd9, 32'd9, 3'b000, 1'b0, 1'b0, 1'b0);
      wait_check(32'd18, 1'b1, 1'b0, 1, "pre_rst_add");
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_valid", 32'(o_valid), 32'd0);
      chk("midrst_result", o_result, 32'd0);
      chk("midrst_flags", {30'd0, o_eq, o_lt}, 32'd0);
      rst = 1'b0;
      rdy = 1'b1;
      #1;
      chk("midrst_ready", 32'(o_ready), 32'd1);

      // Randomized operations against the reference model.
      for (int i = 0; i < 300; i++) begin
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
         rs  = 3'($urandom_range(0, 7));
         rsu = 1'($urandom_range(0, 1));
         run = 1'($urandom_range(0, 1));
         rar = 1'($urandom_range(0, 1));
         m = ref_model(ra, rb, rs, rsu, run, rar);
         drive_op(ra, rb, rs, rsu, run, rar);
         wait_check(m[31:0], m[32], m[33], exp_lat(rs, rb, STEP), $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
